// File: rtl/mem_port_arbiter_pkg.sv
// ------------------------------------------------------------------
// mem_arb_pkg : shared types and indices for mem_port_arbiter. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

  localparam int REQ_DATA  = 0;
  localparam int REQ_FETCH = 1;
  localparam int REQ_DBG   = 2;
  localparam int NUM_REQ   = 3;

  // Successor in the 0->1->2->0 ring; code 3 never occurs but maps to 0.
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
// ------------------------------------------------------------------
// mem_port_arbiter_if : requester and memory-side bus bundle. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] we;
  logic [ADDR_W-1:0]  addr0;
  logic [ADDR_W-1:0]  addr1;
  logic [ADDR_W-1:0]  addr2;
  logic [DATA_W-1:0]  wdata0;
  logic [DATA_W-1:0]  wdata1;
  logic [DATA_W-1:0]  wdata2;
  logic [NUM_REQ-1:0] ack;
  logic [DATA_W-1:0]  rdata;
  logic               mem_en;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [DATA_W-1:0]  mem_wdata;
  logic [DATA_W-1:0]  mem_rdata;
  logic               busy;
  logic [1:0]         grant_id;

  modport slave (
    input  req, we, addr0, addr1, addr2, wdata0, wdata1, wdata2, mem_rdata,
    output ack, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy, grant_id
  );

  modport master (
    output req, we, addr0, addr1, addr2, wdata0, wdata1, wdata2, mem_rdata,
    input  ack, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy, grant_id
  );

endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter_rr_pick3.sv
// ------------------------------------------------------------------
// rr_pick3 : combinational 3-way round-robin selector. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module rr_pick3
  import mem_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         last,
  output logic               valid,
  output logic [1:0]         winner
);

  logic [1:0] w_c1;
  logic [1:0] w_c2;
  logic [1:0] w_c3;

  // Search order last+1, last+2, last: the previous winner ranks lowest.
  assign w_c1  = rr_next(last);
  assign w_c2  = rr_next(w_c1);
  assign w_c3  = rr_next(w_c2);
  assign valid = |req;

  always_comb begin
    winner = w_c1;
    if (req[w_c1])      winner = w_c1;
    else if (req[w_c2]) winner = w_c2;
    else if (req[w_c3]) winner = w_c3;
  end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ------------------------------------------------------------------
// mem_port_arbiter : serialises three requesters onto one memory port
// with fixed wait states and a one-cycle ack. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64,
  parameter int WAIT_STATES = 2
)(
  input  logic              clock,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  localparam int               CNT_W       = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CNT_W-1:0] C_WAIT_LOAD = CNT_W'(WAIT_STATES);

  arb_state_t         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [1:0]         r_last;
  logic [1:0]         r_grant;
  logic               r_mem_en;
  logic               r_mem_we;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [DATA_W-1:0]  r_mem_wdata;
  logic [DATA_W-1:0]  r_rdata;

  logic               w_valid;
  logic [1:0]         w_winner;
  logic               w_sel_we;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [DATA_W-1:0]  w_sel_wdata;
  logic [NUM_REQ-1:0] w_ack;

  rr_pick3 u_pick (
    .req    (bus.req),
    .last   (r_last),
    .valid  (w_valid),
    .winner (w_winner)
  );

  always_comb begin
    w_sel_we    = bus.we[w_winner];
    w_sel_addr  = bus.addr0;
    w_sel_wdata = bus.wdata0;
    case (w_winner)
      2'(REQ_DATA):  begin w_sel_addr = bus.addr0; w_sel_wdata = bus.wdata0; end
      2'(REQ_FETCH): begin w_sel_addr = bus.addr1; w_sel_wdata = bus.wdata1; end
      2'(REQ_DBG):   begin w_sel_addr = bus.addr2; w_sel_wdata = bus.wdata2; end
      default:       begin w_sel_addr = bus.addr0; w_sel_wdata = bus.wdata0; end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_last      <= 2'd2;
      r_grant     <= 2'd0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rdata     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_grant     <= w_winner;
            r_last      <= w_winner;
            r_mem_en    <= 1'b1;
            r_mem_we    <= w_sel_we;
            r_mem_addr  <= w_sel_addr;
            r_mem_wdata <= w_sel_wdata;
            r_cnt       <= C_WAIT_LOAD;
            r_state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            // Memory read data is valid only in the final strobe cycle.
            if (!r_mem_we) r_rdata <= bus.mem_rdata;
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
            r_state  <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    w_ack = '0;
    if (r_state == DONE) w_ack[r_grant] = 1'b1;
  end

  assign bus.ack       = w_ack;
  assign bus.busy      = (r_state != IDLE);
  assign bus.rdata     = r_rdata;
  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.grant_id  = r_grant;

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Multi-cycle arbiter that shares the CPU's single memory port between three requesters: data access (MW / memory-read paths driven by the control word), instruction fetch (IF state, IL), and a debug/load port. It serialises accesses, inserts a fixed number of memory wait states, and returns a one-cycle acknowledge with read data. The control unit holds its state register while waiting for the acknowledge.

## Interface
- `ADDR_W`, 64, address width.
- `DATA_W`, 64, data width.
- `WAIT_STATES`, 2, extra memory cycles per access (0 legal).

- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low; all state cleared while low.
- `req`  in  3  request per requester: [0] data, [1] fetch, [2] debug.
- `we`  in  3  write enable per requester.
- `addr0/addr1/addr2`  in  ADDR_W each  per-requester address.
- `wdata0/wdata1/wdata2`  in  DATA_W each  per-requester write data.
- `ack`  out  3  one-cycle completion pulse, one-hot or zero.
- `rdata`  out  DATA_W  read data, valid in `ack` cycle.
- `mem_en`  out  1  memory access strobe.
- `mem_we`  out  1  memory write strobe.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data, valid in last `mem_en` cycle.
- `busy`  out  1  high in ACCESS and DONE.
- `grant_id`  out  2  index of current/last granted requester.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: if any `req` high, pick winner round-robin starting at (`last`+1) mod 3; register winner's `we`, address, wdata into mem_* regs; set `grant_id`, `last`; load wait counter with WAIT_STATES; go ACCESS. No request: stay.
- ACCESS: `mem_en`=1, `mem_we`=latched we. Counter nonzero: decrement, stay. Counter zero: capture `mem_rdata` into `rdata` on reads (writes leave `rdata` unchanged); go DONE.
- DONE: `ack[grant_id]`=1 for exactly this cycle; go IDLE.
- Requesters hold `req`, `we`, address, wdata stable until `ack`, then drop `req` next cycle or present a new request.
- `req` withdrawn during ACCESS: access still completes and `ack` still pulses.
- Requests arriving while busy wait; no queueing beyond `req` levels.
- Out-of-range counter/pointer states impossible by construction; pointer encoding 3 never produced.
- Reset (asserted any time, including mid-access): state IDLE, `mem_en`=0, `mem_we`=0, `ack`=0, `busy`=0, `grant_id`=0, `rdata`=0, mem_addr/mem_wdata=0, `last`=2 (so requester 0 wins first).

## Timing
- Request sampled in cycle 0 (IDLE) -> `mem_en` high cycles 1..WAIT_STATES+1 -> `ack` in cycle WAIT_STATES+2.
- Default WAIT_STATES=2: `ack` 4 cycles after request sampled; WAIT_STATES=0: 2 cycles.
- Minimum spacing between grants: WAIT_STATES+3 cycles (DONE always returns to IDLE).
- All outputs registered except `ack`, `busy` (decoded from state register).
- `rdata` holds until next read completes.

## Structure
- Shared package `mem_arb_pkg`: state enum (IDLE/ACCESS/DONE), requester indices REQ_DATA=0, REQ_FETCH=1, REQ_DBG=2, NUM_REQ=3.
- Sub-module `rr_pick3`: combinational round-robin selector (inputs `req[2:0]`, `last[1:0]`; outputs `valid`, `winner[1:0]`).
- Wait counter width: clog2(WAIT_STATES+1), minimum 1.

## Test plan
- Reset release, fetch read addr 0x100, mem_rdata=0xDEAD_BEEF -> mem_en cycles 1-3, ack=3'b010 cycle 4, rdata=0xDEADBEEF.
- req=3'b111 held, ack each on receipt -> grant order 0,1,2,0; each ack 4 cycles after grant, grants 5 cycles apart.
- Data write addr 0x40, wdata 0x1234 -> mem_we=1 with mem_en cycles 1-3, ack=3'b001, rdata unchanged from prior read.
- WAIT_STATES=0 build, debug read -> single mem_en cycle, ack=3'b100 cycle 2.
- Reset asserted during ACCESS cycle 2 -> mem_en, ack, busy low immediately; after release fetch req wins only if req[0] low; no stale ack.
- req[1] dropped mid-ACCESS -> access completes, ack=3'b010 still pulses once.
